// File: rtl/countdown16.sv
// 16-bit loadable down-counter with pause/resume, optional auto-reload and an
// expiry event counter; all outputs registered, synchronous active-low reset.
//
// state | meaning
// IDLE  | stopped; count holds loaded value or 0 after expiry
// RUN   | decrementing once per edge
// HOLD  | paused mid-run; count frozen until start
module countdown16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        start,
    input  logic        pause,
    input  logic        auto_reload,
    output logic [15:0] count,
    output logic        busy,
    output logic        expired,
    output logic [7:0]  expire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] reload_reg;
    logic [15:0] reload_nxt;
    logic [15:0] count_nxt;
    logic        expired_nxt;
    logic [7:0]  ecnt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= 16'd0;
            reload_reg <= 16'd0;
            expired    <= 1'b0;
            expire_cnt <= 8'd0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            reload_reg <= reload_nxt;
            expired    <= expired_nxt;
            expire_cnt <= ecnt_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (start && count != 16'd0) state_nxt = RUN;
                RUN: begin
                    if (pause)
                        state_nxt = HOLD;
                    // count == 0 in RUN is unreachable, but leave rather than underflow
                    else if (count == 16'd0 || (count == 16'd1 && !auto_reload))
                        state_nxt = IDLE;
                end
                HOLD: if (start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        count_nxt   = count;
        reload_nxt  = reload_reg;
        expired_nxt = 1'b0;
        ecnt_nxt    = expire_cnt;
        if (load) begin
            count_nxt  = din;
            reload_nxt = din;
            ecnt_nxt   = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && count == 16'd0) begin
                        expired_nxt = 1'b1;
                        ecnt_nxt    = expire_cnt + 8'd1;
                    end
                end
                RUN: begin
                    if (!pause) begin
                        if (count == 16'd1) begin
                            expired_nxt = 1'b1;
                            ecnt_nxt    = expire_cnt + 8'd1;
                            count_nxt   = auto_reload ? reload_reg : 16'd0;
                        end else if (count != 16'd0) begin
                            count_nxt = count - 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_countdown16.sv
// Scenario bench for countdown16: each task queues expected outputs as it
// drives a cycle and compares them against the DUT one edge later.
module tb_countdown16;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic        start;
    logic        pause;
    logic        auto_reload;
    logic [15:0] count;
    logic        busy;
    logic        expired;
    logic [7:0]  expire_cnt;

    int total  = 0;
    int passed = 0;

    typedef struct packed {
        logic [15:0] count;
        logic        busy;
        logic        expired;
        logic [7:0]  ecnt;
    } obs_t;

    typedef struct packed {
        logic        rn;
        logic        ld;
        logic [15:0] d;
        logic        st;
        logic        ps;
        logic        ar;
        obs_t        e;
    } vec_t;

    obs_t sb[$];

    countdown16 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .din         (din),
        .start       (start),
        .pause       (pause),
        .auto_reload (auto_reload),
        .count       (count),
        .busy        (busy),
        .expired     (expired),
        .expire_cnt  (expire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [15:0] d, input logic st,
                                input logic ps, input logic ar, input logic [15:0] ec,
                                input logic eb, input logic ee, input logic [7:0] ek);
        vec_t v;
        v.rn = 1'b1; v.ld = ld; v.d = d; v.st = st; v.ps = ps; v.ar = ar;
        v.e.count = ec; v.e.busy = eb; v.e.expired = ee; v.e.ecnt = ek;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst_n = v.rn; load = v.ld; din = v.d; start = v.st; pause = v.ps; auto_reload = v.ar;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        obs_t got, want;
        vec_t r;
        r = mk(1, 16'd55, 1, 1, 1, 16'd0, 0, 0, 8'd0);
        r.rn = 1'b0;
        v.push_back(r);
        v.push_back(r);
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd0));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL reset[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_basic();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd3, 0, 0, 0, 16'd3, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd2, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd1, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 8'd1));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd1));
        v.push_back(mk(0, 0, 0, 1, 0, 16'd0, 0, 0, 8'd1));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL basic[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_auto_reload();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd2, 0, 0, 1, 16'd2, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 1, 16'd2, 1, 0, 8'd0));
        for (int k = 1; k <= 3; k++) begin
            v.push_back(mk(0, 0, 0, 0, 1, 16'd1, 1, 0, 8'(k - 1)));
            v.push_back(mk(0, 0, 0, 0, 1, 16'd2, 1, 1, 8'(k)));
        end
        v.push_back(mk(0, 0, 0, 0, 0, 16'd1, 1, 0, 8'd3));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 8'd4));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL auto_reload[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_pause();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd5, 0, 0, 0, 16'd5, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd5, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd4, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 1, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 1, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd2, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd1, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 8'd1));
        v.push_back(mk(0, 0, 0, 1, 0, 16'd0, 0, 0, 8'd1));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL pause[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_start_pause();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd4, 0, 0, 0, 16'd4, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd4, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 1, 0, 16'd4, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 1, 0, 16'd4, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd3, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd2, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd1, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 1, 1, 16'd1, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd1, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 8'd1));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL start_pause[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_zero();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd0, 0, 0, 0, 16'd0, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd0, 0, 1, 8'd1));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd1));
        v.push_back(mk(0, 0, 1, 0, 1, 16'd0, 0, 1, 8'd2));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd2));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL zero[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_abort();
        vec_t v[$];
        obs_t got, want;
        vec_t r;
        v.push_back(mk(1, 16'd10, 0, 0, 0, 16'd10, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd10, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd9, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd8, 1, 0, 8'd0));
        v.push_back(mk(1, 16'd7, 1, 1, 0, 16'd7, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 0, 16'd7, 1, 0, 8'd0));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd6, 1, 0, 8'd0));
        r = mk(1, 16'd9, 1, 0, 1, 16'd0, 0, 0, 8'd0);
        r.rn = 1'b0;
        v.push_back(r);
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd0));
        // reload register must have been cleared by reset as well
        v.push_back(mk(0, 0, 1, 0, 1, 16'd0, 0, 1, 8'd1));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL abort[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        vec_t v[$];
        obs_t got, want;
        v.push_back(mk(1, 16'd1, 0, 0, 1, 16'd1, 0, 0, 8'd0));
        v.push_back(mk(0, 0, 1, 0, 1, 16'd1, 1, 0, 8'd0));
        for (int k = 1; k <= 256; k++)
            v.push_back(mk(0, 0, 0, 0, 1, 16'd1, 1, 1, 8'(k)));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 1, 8'd1));
        v.push_back(mk(0, 0, 0, 0, 0, 16'd0, 0, 0, 8'd1));
        foreach (v[i]) begin
            apply(v[i]);
            sb.push_back(v[i].e);
            tick();
            got = {count, busy, expired, expire_cnt};
            want = sb.pop_front();
            total++;
            if (got !== want)
                $display("FAIL wrap[%0d] got count=%0d busy=%b exp=%b ecnt=%0d want count=%0d busy=%b exp=%b ecnt=%0d",
                         i, got.count, got.busy, got.expired, got.ecnt, want.count, want.busy, want.expired, want.ecnt);
            else passed++;
        end
    endtask

    initial begin
        rst_n = 1'b0; load = 1'b0; din = 16'd0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
        #2;
        test_reset();
        test_basic();
        test_auto_reload();
        test_pause();
        test_start_pause();
        test_zero();
        test_abort();
        test_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
